// File: rtl/bp_be_pkg.sv
// Shared FP back-end definitions: divide-controller states, rounding-mode and
// fflags encodings, and canonical NaN values.
package bp_be_pkg;

    typedef enum logic [2:0] {
        E_DIV_IDLE,
        E_DIV_ISSUE,
        E_DIV_BUSY,
        E_DIV_DONE,
        E_DIV_DRAIN
    } bp_be_fp_div_state_e;

    localparam logic [2:0] e_dyn = 3'b111;

    localparam int unsigned fflag_nv_lp = 4;
    localparam int unsigned fflag_dz_lp = 3;
    localparam int unsigned fflag_of_lp = 2;
    localparam int unsigned fflag_uf_lp = 1;
    localparam int unsigned fflag_nx_lp = 0;

    localparam logic [63:0] canonical_nan_dp_lp = 64'h7FF8_0000_0000_0000;
    // Single-precision NaN is NaN-boxed into the upper word.
    localparam logic [63:0] canonical_nan_sp_lp = 64'hFFFF_FFFF_7FC0_0000;

endpackage

// File: rtl/bp_be_fp_rm_resolve.sv
// Resolves the dynamic rounding mode against the CSR value and flags the
// reserved encodings (5, 6, 7) as illegal.
module bp_be_fp_rm_resolve
    import bp_be_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    output logic [2:0] rm_o,
    output logic       illegal_o
);

    assign rm_o      = (rm_i == e_dyn) ? frm_i : rm_i;
    assign illegal_o = (rm_o >= 3'd5);

endmodule

// File: rtl/bp_be_fp_div_ctrl.sv
// Sequencer for the shared FP divide/sqrt unit: accept, issue, wait, hold for
// writeback, sticky fflags. Optional watchdog: BP_BE_FP_DIV_CTRL_TIMEOUT_EN.
module bp_be_fp_div_ctrl
    import bp_be_pkg::*;
#(
    parameter int reg_data_width_p = 64,
    parameter int rd_addr_width_p  = 5,
    parameter int timeout_p        = 128
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic                        sqrt_i,
    input  logic                        dp_i,
    input  logic [2:0]                  rm_i,
    input  logic [2:0]                  frm_i,
    input  logic [reg_data_width_p-1:0] rs1_i,
    input  logic [reg_data_width_p-1:0] rs2_i,
    input  logic [rd_addr_width_p-1:0]  rd_i,
    input  logic                        flush_i,
    output logic                        unit_v_o,
    input  logic                        unit_ready_i,
    output logic                        unit_sqrt_o,
    output logic                        unit_dp_o,
    output logic [2:0]                  unit_rm_o,
    output logic [reg_data_width_p-1:0] unit_a_o,
    output logic [reg_data_width_p-1:0] unit_b_o,
    input  logic                        unit_v_i,
    input  logic [reg_data_width_p-1:0] unit_data_i,
    input  logic [4:0]                  unit_eflags_i,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic [reg_data_width_p-1:0] data_o,
    output logic [rd_addr_width_p-1:0]  rd_o,
    output logic                        illegal_o,
    output logic [4:0]                  fflags_o,
    input  logic                        fflags_clr_i
);

    bp_be_fp_div_state_e state_q, state_d;

    logic                        sqrt_q, dp_q, illegal_q;
    logic [2:0]                  rm_q;
    logic [reg_data_width_p-1:0] a_q, b_q;
    logic [rd_addr_width_p-1:0]  rd_q;
    logic [reg_data_width_p-1:0] data_q, data_d;
    logic [4:0]                  eflags_q, eflags_d;
    logic [4:0]                  fflags_q, fflags_d;

    logic [2:0] rm_res;
    logic       rm_illegal;
    logic       accept;
    logic       timeout;

    bp_be_fp_rm_resolve rm_resolve (
        .rm_i      (rm_i),
        .frm_i     (frm_i),
        .rm_o      (rm_res),
        .illegal_o (rm_illegal)
    );

    // A flush in IDLE kills a same-cycle request.
    assign accept = v_i & (state_q == E_DIV_IDLE) & ~flush_i;

`ifdef BP_BE_FP_DIV_CTRL_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == 8'(timeout_p - 1));

    // Restarts from zero on every state change, so entering BUSY or DRAIN
    // always begins a fresh count.
    always_comb begin
        cnt_d = '0;
        if ((state_q == E_DIV_BUSY || state_q == E_DIV_DRAIN) && state_d == state_q)
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    // No watchdog: timeout_p is non-negative, so this never fires.
    assign timeout = (timeout_p < 0);
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        eflags_d = eflags_q;
        fflags_d = fflags_q;
        unique case (state_q)
            E_DIV_IDLE: begin
                if (accept) begin
                    state_d  = rm_illegal ? E_DIV_DONE : E_DIV_ISSUE;
                    data_d   = '0;
                    eflags_d = '0;
                end
            end
            E_DIV_ISSUE: begin
                if (flush_i)           state_d = E_DIV_IDLE;
                else if (unit_ready_i) state_d = E_DIV_BUSY;
            end
            E_DIV_BUSY: begin
                // A result landing on the flush cycle needs no drain.
                if (unit_v_i) begin
                    if (flush_i) begin
                        state_d = E_DIV_IDLE;
                    end else begin
                        state_d  = E_DIV_DONE;
                        data_d   = unit_data_i;
                        eflags_d = unit_eflags_i;
                    end
                end else if (flush_i) begin
                    state_d = E_DIV_DRAIN;
                end else if (timeout) begin
                    state_d  = E_DIV_DONE;
                    data_d   = dp_q ? reg_data_width_p'(canonical_nan_dp_lp)
                                    : reg_data_width_p'(canonical_nan_sp_lp);
                    eflags_d = '0;
                    eflags_d[fflag_nv_lp] = 1'b1;
                end
            end
            E_DIV_DRAIN: begin
                if (unit_v_i || timeout) state_d = E_DIV_IDLE;
            end
            E_DIV_DONE: begin
                if (flush_i) begin
                    state_d = E_DIV_IDLE;
                end else if (yumi_i) begin
                    state_d = E_DIV_IDLE;
                    if (!illegal_q) fflags_d = fflags_q | eflags_q;
                end
            end
            default: state_d = E_DIV_IDLE;
        endcase
        if (fflags_clr_i) fflags_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= E_DIV_IDLE;
            sqrt_q    <= 1'b0;
            dp_q      <= 1'b0;
            illegal_q <= 1'b0;
            rm_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            eflags_q  <= '0;
            fflags_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            eflags_q <= eflags_d;
            fflags_q <= fflags_d;
            if (accept) begin
                sqrt_q    <= sqrt_i;
                dp_q      <= dp_i;
                illegal_q <= rm_illegal;
                rm_q      <= rm_res;
                a_q       <= rs1_i;
                b_q       <= rs2_i;
                rd_q      <= rd_i;
            end
        end
    end

    assign ready_o     = (state_q == E_DIV_IDLE);
    assign unit_v_o    = (state_q == E_DIV_ISSUE) & ~flush_i;
    assign unit_sqrt_o = sqrt_q;
    assign unit_dp_o   = dp_q;
    assign unit_rm_o   = rm_q;
    assign unit_a_o    = a_q;
    assign unit_b_o    = b_q;
    assign v_o         = (state_q == E_DIV_DONE);
    assign data_o      = data_q;
    assign rd_o        = rd_q;
    assign illegal_o   = v_o & illegal_q;
    assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_bp_be_fp_div_ctrl.sv
// Randomized and directed bench for bp_be_fp_div_ctrl against a
// transaction-level model of rm resolution, latency and sticky flags.
module tb_bp_be_fp_div_ctrl;

`ifdef BP_BE_FP_DIV_CTRL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 128;
`endif

    logic        clk = 1'b0;
    logic        reset_i, v_i, ready_o, sqrt_i, dp_i, flush_i;
    logic [2:0]  rm_i, frm_i, unit_rm_o;
    logic [63:0] rs1_i, rs2_i, unit_a_o, unit_b_o, unit_data_i, data_o;
    logic [4:0]  rd_i, rd_o, unit_eflags_i, fflags_o;
    logic        unit_v_o, unit_ready_i, unit_sqrt_o, unit_dp_o, unit_v_i;
    logic        v_o, yumi_i, illegal_o, fflags_clr_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  ref_fflags = '0;

    bp_be_fp_div_ctrl #(.reg_data_width_p(64), .rd_addr_width_p(5), .timeout_p(TO)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .sqrt_i(sqrt_i), .dp_i(dp_i), .rm_i(rm_i), .frm_i(frm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
        .unit_v_o(unit_v_o), .unit_ready_i(unit_ready_i), .unit_sqrt_o(unit_sqrt_o),
        .unit_dp_o(unit_dp_o), .unit_rm_o(unit_rm_o), .unit_a_o(unit_a_o),
        .unit_b_o(unit_b_o), .unit_v_i(unit_v_i), .unit_data_i(unit_data_i),
        .unit_eflags_i(unit_eflags_i), .v_o(v_o), .yumi_i(yumi_i), .data_o(data_o),
        .rd_o(rd_o), .illegal_o(illegal_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ref_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == 3'd7) ? frm : rm;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic sq, input logic dpv, input logic [2:0] rm,
                             input logic [2:0] frm, input logic [63:0] a,
                             input logic [63:0] b, input logic [4:0] rd);
        v_i = 1'b1; sqrt_i = sq; dp_i = dpv; rm_i = rm; frm_i = frm;
        rs1_i = a; rs2_i = b; rd_i = rd;
        tick();
        v_i = 1'b0; rm_i = 3'($urandom); frm_i = 3'($urandom);
        rs1_i = {$urandom, $urandom}; rs2_i = {$urandom, $urandom};
    endtask

    // One full request: accept, optional issue stall, unit latency, writeback hold.
    task automatic txn(input string tag, input logic sq, input logic dpv,
                       input logic [2:0] rm, input logic [2:0] frm,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input int stall, input int lat, input logic [4:0] ef,
                       input logic [63:0] res, input int hold, input bit clr);
        logic [2:0]  er;
        bit          ill;
        logic [63:0] edata;
        er = ref_rm(rm, frm);
        ill = (er >= 3'd5);
        edata = ill ? 64'd0 : res;
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL %s ready_before: got %b want 1", tag, ready_o); end
        start_req(sq, dpv, rm, frm, a, b, rd);
        if (!ill) begin
            for (int i = 0; i <= stall; i++) begin
                n_cmp++;
                if ({unit_v_o, unit_rm_o, unit_sqrt_o, unit_dp_o} !== {1'b1, er, sq, dpv}) begin
                    n_err++;
                    $display("FAIL %s issue_ctl: got v=%b rm=%0d sq=%b dp=%b want v=1 rm=%0d sq=%b dp=%b",
                             tag, unit_v_o, unit_rm_o, unit_sqrt_o, unit_dp_o, er, sq, dpv);
                end
                n_cmp++;
                if ({unit_a_o, unit_b_o} !== {a, b}) begin
                    n_err++;
                    $display("FAIL %s issue_ops: got %h/%h want %h/%h", tag, unit_a_o, unit_b_o, a, b);
                end
                unit_ready_i = (i == stall);
                tick();
            end
            unit_ready_i = 1'b0;
            for (int i = 1; i < lat; i++) begin
                n_cmp++;
                if ({unit_v_o, v_o, ready_o} !== 3'b000) begin
                    n_err++;
                    $display("FAIL %s busy: got unit_v=%b v=%b ready=%b want 000", tag, unit_v_o, v_o, ready_o);
                end
                tick();
            end
            unit_v_i = 1'b1; unit_data_i = res; unit_eflags_i = ef;
            tick();
            unit_v_i = 1'b0; unit_data_i = {$urandom, $urandom}; unit_eflags_i = 5'($urandom);
        end
        for (int h = 0; h <= hold; h++) begin
            n_cmp++;
            if ({v_o, ready_o, unit_v_o, illegal_o} !== {3'b100, ill}) begin
                n_err++;
                $display("FAIL %s done_ctl: got v=%b rdy=%b uv=%b ill=%b want 1 0 0 %b",
                         tag, v_o, ready_o, unit_v_o, illegal_o, ill);
            end
            n_cmp++;
            if ({data_o, rd_o, fflags_o} !== {edata, rd, ref_fflags}) begin
                n_err++;
                $display("FAIL %s done_data: got %h rd=%0d ff=%b want %h rd=%0d ff=%b",
                         tag, data_o, rd_o, fflags_o, edata, rd, ref_fflags);
            end
            if (h == hold) begin
                yumi_i = 1'b1; fflags_clr_i = clr;
            end else begin
                unit_v_i = 1'($urandom); // stray pulses must be ignored
            end
            tick();
            unit_v_i = 1'b0; yumi_i = 1'b0; fflags_clr_i = 1'b0;
        end
        if (clr) ref_fflags = '0;
        else if (!ill) ref_fflags = ref_fflags | ef;
        n_cmp++;
        if ({ready_o, v_o, fflags_o} !== {2'b10, ref_fflags}) begin
            n_err++;
            $display("FAIL %s after_yumi: got rdy=%b v=%b ff=%b want 1 0 %b", tag, ready_o, v_o, fflags_o, ref_fflags);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
        ref_fflags = '0;
        n_cmp++;
        if ({ready_o, v_o, unit_v_o, illegal_o, fflags_o} !== {4'b1000, 5'b0}) begin
            n_err++;
            $display("FAIL reset_ctl: got rdy=%b v=%b uv=%b ill=%b ff=%b want 1 0 0 0 00000",
                     ready_o, v_o, unit_v_o, illegal_o, fflags_o);
        end
        n_cmp++;
        if ({data_o, unit_a_o, unit_b_o, rd_o, unit_rm_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h %h %h %h want 0", data_o, unit_a_o, unit_b_o, rd_o, unit_rm_o);
        end
    endtask

    task automatic test_fdiv_dyn();
        txn("fdiv_dyn", 1'b0, 1'b1, 3'd7, 3'd1, 64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000,
            5'd3, 0, 10, 5'b00001, 64'h4000_0000_0000_0000, 0, 1'b0);
        n_cmp++;
        if (fflags_o !== 5'b00001) begin n_err++; $display("FAIL fdiv_dyn_fflags: got %b want 00001", fflags_o); end
    endtask

    task automatic test_illegal();
        txn("illegal_rm5", 1'b0, 1'b1, 3'd5, 3'd0, 64'h1, 64'h2, 5'd9, 0, 1, 5'b11111, 64'hDEAD, 0, 1'b0);
        txn("illegal_frm6", 1'b1, 1'b0, 3'd7, 3'd6, 64'h3, 64'h4, 5'd10, 0, 1, 5'b11111, 64'hBEEF, 2, 1'b0);
    endtask

    task automatic test_hold();
        txn("hold5", 1'b1, 1'b1, 3'd2, 3'd0, 64'h4020_0000_0000_0000, 64'h0,
            5'd17, 1, 3, 5'b00100, 64'h4008_0000_0000_0000, 5, 1'b0);
    endtask

    task automatic test_clr();
        txn("clr_yumi", 1'b0, 1'b0, 3'd0, 3'd0, 64'h5, 64'h6, 5'd4, 0, 2, 5'b01000, 64'h7, 1, 1'b1);
        n_cmp++;
        if (fflags_o !== 5'b00000) begin n_err++; $display("FAIL clr_yumi_zero: got %b want 00000", fflags_o); end
    endtask

    task automatic test_flush();
        // IDLE: request dropped
        v_i = 1'b1; flush_i = 1'b1; rm_i = 3'd0;
        tick();
        v_i = 1'b0; flush_i = 1'b0;
        n_cmp++;
        if ({ready_o, unit_v_o, v_o} !== 3'b100) begin
            n_err++; $display("FAIL flush_idle: got rdy=%b uv=%b v=%b want 100", ready_o, unit_v_o, v_o);
        end
        // ISSUE: no handshake even with the unit ready
        start_req(1'b0, 1'b1, 3'd1, 3'd0, 64'h11, 64'h22, 5'd1);
        flush_i = 1'b1; unit_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (unit_v_o !== 1'b0) begin n_err++; $display("FAIL flush_issue_strobe: got %b want 0", unit_v_o); end
        tick();
        flush_i = 1'b0; unit_ready_i = 1'b0;
        n_cmp++;
        if ({ready_o, unit_v_o, v_o} !== 3'b100) begin
            n_err++; $display("FAIL flush_issue: got rdy=%b uv=%b v=%b want 100", ready_o, unit_v_o, v_o);
        end
        // BUSY: drain the late result, drop its flags
        start_req(1'b1, 1'b1, 3'd0, 3'd0, 64'h33, 64'h44, 5'd2);
        unit_ready_i = 1'b1;
        tick();
        unit_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ready_o, v_o, unit_v_o} !== 3'b000) begin
                n_err++; $display("FAIL flush_drain_wait: got rdy=%b v=%b uv=%b want 000", ready_o, v_o, unit_v_o);
            end
            tick();
        end
        unit_v_i = 1'b1; unit_eflags_i = 5'b10000; unit_data_i = 64'h55;
        tick();
        unit_v_i = 1'b0;
        n_cmp++;
        if ({ready_o, v_o, fflags_o} !== {2'b10, ref_fflags}) begin
            n_err++; $display("FAIL flush_drain_end: got rdy=%b v=%b ff=%b want 1 0 %b", ready_o, v_o, fflags_o, ref_fflags);
        end
        // DONE: result discarded, no flag update
        start_req(1'b0, 1'b0, 3'd3, 3'd0, 64'h66, 64'h77, 5'd6);
        unit_ready_i = 1'b1;
        tick();
        unit_ready_i = 1'b0; unit_v_i = 1'b1; unit_eflags_i = 5'b00010;
        tick();
        unit_v_i = 1'b0; flush_i = 1'b1; yumi_i = 1'b1;
        tick();
        flush_i = 1'b0; yumi_i = 1'b0;
        n_cmp++;
        if ({ready_o, v_o, fflags_o} !== {2'b10, ref_fflags}) begin
            n_err++; $display("FAIL flush_done: got rdy=%b v=%b ff=%b want 1 0 %b", ready_o, v_o, fflags_o, ref_fflags);
        end
    endtask

    task automatic test_reset_mid();
        txn("pre_rst", 1'b0, 1'b1, 3'd4, 3'd0, 64'h8, 64'h9, 5'd5, 0, 1, 5'b00011, 64'hA, 0, 1'b0);
        start_req(1'b0, 1'b1, 3'd0, 3'd0, 64'h1, 64'h2, 5'd7);
        unit_ready_i = 1'b1;
        tick();
        unit_ready_i = 1'b0; reset_i = 1'b1;
        tick();
        reset_i = 1'b0; ref_fflags = '0;
        n_cmp++;
        if ({ready_o, v_o, unit_v_o, fflags_o} !== {3'b100, 5'b0}) begin
            n_err++; $display("FAIL reset_mid: got rdy=%b v=%b uv=%b ff=%b want 1 0 0 00000", ready_o, v_o, unit_v_o, fflags_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            txn("random", 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                $urandom_range(0, 2), $urandom_range(1, 6), 5'($urandom),
                {$urandom, $urandom}, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end
    endtask

`ifdef BP_BE_FP_DIV_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        start_req(1'b0, 1'b1, 3'd0, 3'd0, 64'h1, 64'h0, 5'd8);
        unit_ready_i = 1'b1;
        tick();
        unit_ready_i = 1'b0;
        for (int i = 0; i < TO; i++) begin
            n_cmp++;
            if (v_o !== 1'b0) begin n_err++; $display("FAIL timeout_early: cycle %0d got v=%b want 0", i, v_o); end
            tick();
        end
        n_cmp++;
        if ({v_o, data_o} !== {1'b1, 64'h7FF8_0000_0000_0000}) begin
            n_err++; $display("FAIL timeout_nan: got v=%b data=%h want 1 7ff8000000000000", v_o, data_o);
        end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        ref_fflags[4] = 1'b1;
        n_cmp++;
        if (fflags_o !== ref_fflags) begin n_err++; $display("FAIL timeout_nv: got %b want %b", fflags_o, ref_fflags); end
    endtask
`endif

    initial begin
        reset_i = 1'b1; v_i = 1'b0; sqrt_i = 1'b0; dp_i = 1'b0; rm_i = '0; frm_i = '0;
        rs1_i = '0; rs2_i = '0; rd_i = '0; flush_i = 1'b0; unit_ready_i = 1'b0;
        unit_v_i = 1'b0; unit_data_i = '0; unit_eflags_i = '0; yumi_i = 1'b0; fflags_clr_i = 1'b0;
        test_reset();
        test_fdiv_dyn();
        test_illegal();
        test_hold();
        test_clr();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef BP_BE_FP_DIV_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_be_fp_div_ctrl.md
Name: bp_be_fp_div_ctrl

Overview:
Controller that sequences a shared, long-latency FP divide/sqrt unit on behalf of the FP pipe. It accepts one fdiv/fsqrt request at a time and resolves the dynamic rounding mode. It issues to the unit, waits for completion, holds the result for writeback, and accumulates sticky exception flags. It also handles pipeline flush while the unit is mid-operation.

Parameters:
reg_data_width_p, 64, operand/result width (rv64 FP register width)
rd_addr_width_p, 5, destination register tag width
timeout_p, 128, watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
v_i  in  1  request valid
ready_o  out  1  controller can accept a request
sqrt_i  in  1  1=fsqrt, 0=fdiv
dp_i  in  1  1=double, 0=single precision
rm_i  in  3  instruction rounding mode
frm_i  in  3  CSR dynamic rounding mode
rs1_i  in  64  dividend / sqrt operand
rs2_i  in  64  divisor (ignored for sqrt)
rd_i  in  5  destination tag
flush_i  in  1  kill the in-flight request
unit_v_o  out  1  issue strobe to the divide unit
unit_ready_i  in  1  unit can accept an issue
unit_sqrt_o, unit_dp_o  out  1 each  latched op fields
unit_rm_o  out  3  resolved rounding mode
unit_a_o, unit_b_o  out  64 each  latched operands
unit_v_i  in  1  unit result valid (single-cycle pulse)
unit_data_i  in  64  unit result
unit_eflags_i  in  5  unit exception flags
v_o  out  1  result valid to writeback
yumi_i  in  1  writeback consumes the result
data_o  out  64  result
rd_o  out  5  destination tag
illegal_o  out  1  request had an invalid resolved rm
fflags_o  out  5  sticky accumulated flags
fflags_clr_i  in  1  clear sticky flags

Behaviour:
- States: IDLE, ISSUE, BUSY, DONE, DRAIN. Reset enters IDLE. All outputs reset to 0; fflags_o resets to 0.
- ready_o = (state==IDLE). Accept on v_i & ready_o: latch all request fields, rm_r = (rm_i==3'b111) ? frm_i : rm_i.
- Illegal rm (resolved rm is 5, 6 or 7): go directly to DONE with illegal_o=1, data_o=0 and no flag update. The unit is never issued.
- Otherwise go to ISSUE.
- ISSUE: unit_v_o=1. On unit_ready_i, go to BUSY. unit_v_o is asserted only in ISSUE.
- BUSY: on unit_v_i, capture data and eflags, go to DONE.
- DONE: v_o=1, outputs stable. On yumi_i, OR the captured eflags into fflags_o and go to IDLE. There is no zero-cycle bypass: minimum latency is accept to v_o in 2 cycles plus unit latency.
- flush_i handling by state:
  - ISSUE: go to IDLE; no issue occurs.
  - BUSY: go to DRAIN; DRAIN waits for unit_v_i, discards the result, then goes to IDLE.
  - DONE: go to IDLE with no flag update.
  - IDLE: a simultaneous v_i is dropped.
- fflags_clr_i takes priority over the same-cycle OR: clear wins, and the new flags are lost.
- ready_o is low in DRAIN. A unit_v_i outside BUSY/DRAIN is ignored.
- Reset mid-operation returns to IDLE. The unit is reset by the same reset_i, so no drain is needed.

Optional Feature:
BP_BE_FP_DIV_CTRL_TIMEOUT_EN:
- Defined: an 8-bit saturating counter runs in BUSY/DRAIN and clears on entry. At count == timeout_p-1 with no unit_v_i:
  - BUSY goes to DONE with data_o = canonical NaN (0x7FF8000000000000 for dp; 0xFFFFFFFF7FC00000 for sp) and NV flag set.
  - DRAIN goes to IDLE.
- Undefined: no counter; the controller waits indefinitely.

Decomposition:
- Shared package (bp_be_pkg): state enum bp_be_fp_div_state_e; rounding-mode dyn encoding e_dyn=3'b111; fflags bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0); canonical NaN constants.
- Sub-module bp_be_fp_rm_resolve: combinational rm/frm resolution and legality check, reusable by other FP pipes.

Test Plan:
- fdiv dp, rm=7, frm=1; unit responds 10 cycles after issue with data 0x4000000000000000, eflags=5'b00001 -> unit_rm_o=1; v_o 12 cycles after accept; after yumi, fflags_o=5'b00001.
- rm=5 request -> no unit_v_o; v_o next+1 cycle with illegal_o=1, data_o=0, fflags unchanged.
- flush_i in BUSY, unit_v_i 4 cycles later with eflags=5'b10000 -> no v_o, ready_o low until that pulse, fflags_o unchanged.
- v_o held with yumi_i low for 5 cycles -> data_o/rd_o stable, ready_o=0; yumi then ready_o=1 next cycle.
- fflags_clr_i same cycle as yumi with eflags=5'b01000 -> fflags_o=0.
- TIMEOUT_EN, timeout_p=16, unit silent -> v_o with data_o=0x7FF8000000000000, fflags_o bit4 set after yumi.
